// File: rtl/wam_pkg.sv
// Shared whack-a-mole constants and the saturating two-digit BCD adder
// (also used by the timer and display blocks).
package wam_pkg;
  localparam int         WAM_HOLES = 8;
  localparam logic [7:0] BCD_MAX   = 8'h99;

  // Valid for inc in 0..9: at most one carry out of the units digit.
  function automatic logic [7:0] bcd_sat_add(input logic [7:0] v, input logic [3:0] inc);
    logic [4:0] u;
    logic [4:0] t;
    u = {1'b0, v[3:0]} + {1'b0, inc};
    t = {1'b0, v[7:4]};
    if (u > 5'd9) begin
      u = u - 5'd10;
      t = t + 5'd1;
    end
    if (t > 5'd9) return BCD_MAX;
    return {t[3:0], u[3:0]};
  endfunction
endpackage

// File: rtl/wam_deb.sv
// One hole button: two-flop synchroniser, counting debouncer, and a
// press strobe asserted on the edge where the debounced level rises.
module wam_deb #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_19,
  input  logic clr,
  input  logic btn_i,
  output logic press_o
);
  localparam logic [3:0] CNT_MAX = 4'(DB_CYCLES - 1);

  logic       s1_q, s2_q, db_q, db_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk_19 or posedge clr) begin
    if (clr) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = 4'd0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) db_d  = s2_q;
      else                  cnt_d = cnt_q + 4'd1;
    end
  end

  // Combinational so the top registers hit/mv on the same edge db rises.
  assign press_o = db_d & ~db_q;
endmodule

// File: rtl/wam_hit.sv
// Player input stage: debounced presses classified into hit/miss pulses,
// then accumulated into saturating BCD score and miss tallies.
module wam_hit
  import wam_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic                 clk_19,
  input  logic                 clr,
  input  logic [WAM_HOLES-1:0] btn,
  input  logic [WAM_HOLES-1:0] holes,
  output logic [WAM_HOLES-1:0] hit,
  output logic [7:0]           score,
  output logic [7:0]           miss
);
  logic [WAM_HOLES-1:0] press;
  logic [WAM_HOLES-1:0] hit_q, mv_q;
  logic [7:0]           score_q, miss_q;

  function automatic logic [3:0] popcnt(input logic [WAM_HOLES-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < WAM_HOLES; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  for (genvar g = 0; g < WAM_HOLES; g++) begin : g_deb
    wam_deb #(.DB_CYCLES(DB_CYCLES)) u_deb (
      .clk_19 (clk_19),
      .clr    (clr),
      .btn_i  (btn[g]),
      .press_o(press[g])
    );
  end

  // holes is sampled on the press edge, before the generator reacts to hit.
  always_ff @(posedge clk_19 or posedge clr) begin
    if (clr) begin
      hit_q   <= '0;
      mv_q    <= '0;
      score_q <= 8'h00;
      miss_q  <= 8'h00;
    end else begin
      hit_q   <= press & holes;
      mv_q    <= press & ~holes;
      score_q <= bcd_sat_add(score_q, popcnt(hit_q));
      miss_q  <= bcd_sat_add(miss_q, popcnt(mv_q));
    end
  end

  assign hit   = hit_q;
  assign score = score_q;
  assign miss  = miss_q;
endmodule

// File: tb/tb_wam_hit.sv
// Directed bench for wam_hit: exact-timing checks in the main sequence plus a
// queue of expected hit pulses consumed by a monitor whenever hit is nonzero.
module tb_wam_hit;
  localparam int DB = 4;

  logic       clk_19 = 1'b0;
  logic       clr;
  logic [7:0] btn, holes, hit, score, miss;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  wam_hit #(.DB_CYCLES(DB)) dut (
    .clk_19(clk_19), .clr(clr), .btn(btn), .holes(holes),
    .hit(hit), .score(score), .miss(miss)
  );

  always #5 clk_19 = ~clk_19;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_19);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Press and release with enough clocks for pulse, tally and release debounce.
  task automatic press(input logic [7:0] m, input logic [7:0] h);
    holes = h;
    btn   = m;
    if ((m & h) != 8'h00) exp_q.push_back(m & h);
    tick(DB + 4);
    btn = 8'h00;
    tick(DB + 4);
  endtask

  always @(negedge clk_19) begin
    if (hit !== 8'h00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL spurious_hit: observed=%h expected=none", hit);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        assert (hit === e) else begin
          errors++;
          $error("FAIL hit_pulse: observed=%h expected=%h", hit, e);
        end
      end
    end
  end

  initial begin
    int t;
    clr = 1'b1; btn = 8'h00; holes = 8'h00;
    tick(2);
    chk("rst_hit", hit, 8'h00);
    chk("rst_score", score, 8'h00);
    chk("rst_miss", miss, 8'h00);
    clr = 1'b0;
    tick(2);

    // Clean press on occupied hole 3: exact pulse window and tally edge.
    holes = 8'h08; btn = 8'h08; exp_q.push_back(8'h08);
    tick(5);  chk("t1_hit_before_E6", hit, 8'h00);
    tick(1);  chk("t1_hit_after_E6", hit, 8'h08);
              chk("t1_score_before_E7", score, 8'h00);
    tick(1);  chk("t1_hit_after_E7", hit, 8'h00);
              chk("t1_score", score, 8'h01);
              chk("t1_miss", miss, 8'h00);
    btn = 8'h00; tick(DB + 4);

    // Bouncing button on an empty hole: 3 high / 1 low never settles.
    holes = 8'h00;
    for (int r = 0; r < 6; r++) begin
      btn = 8'h01; tick(3);
      btn = 8'h00; tick(1);
    end
    tick(DB + 2);
    chk("t2_bounce_miss", miss, 8'h00);
    btn = 8'h01; tick(DB + 6);
    chk("t2_hold_miss", miss, 8'h01);
    chk("t2_hold_score", score, 8'h01);
    btn = 8'h00; tick(DB + 4);

    // Four simultaneous presses, two occupied.
    holes = 8'h05; btn = 8'h0F; exp_q.push_back(8'h05);
    tick(DB + 2); chk("t3_hit", hit, 8'h05);
    tick(1);      chk("t3_score", score, 8'h03);
                  chk("t3_miss", miss, 8'h03);
    btn = 8'h00; tick(DB + 4);

    // BCD carry and saturation from a clean tally.
    clr = 1'b1; tick(1); clr = 1'b0; tick(1);
    for (int k = 0; k < 9; k++) press(8'h01, 8'h01);
    chk("t4_nine", score, 8'h09);
    press(8'hFF, 8'hFF);
    chk("t4_carry17", score, 8'h17);
    for (int k = 0; k < 10; k++) press(8'hFF, 8'hFF);
    press(8'h02, 8'h02);
    chk("t4_98", score, 8'h98);
    press(8'hFF, 8'hFF);
    chk("t4_sat99", score, 8'h99);
    press(8'h10, 8'h10);
    chk("t4_stay99", score, 8'h99);
    chk("t4_miss", miss, 8'h00);

    // Held button: one pulse only.
    clr = 1'b1; tick(1); clr = 1'b0; tick(1);
    holes = 8'h20; btn = 8'h20; exp_q.push_back(8'h20);
    tick(100);
    chk("t5_held_score", score, 8'h01);
    btn = 8'h00; tick(DB + 4);

    // Reset mid-debounce clears at once; the held button then scores once.
    holes = 8'h80; btn = 8'h80;
    tick(2);
    clr = 1'b1; #1;
    chk("t6_async_score", score, 8'h00);
    chk("t6_async_hit", hit, 8'h00);
    chk("t6_async_miss", miss, 8'h00);
    tick(1);
    clr = 1'b0;
    exp_q.push_back(8'h80);
    t = 0;
    while (score == 8'h00 && t < 4 * DB + 8) begin
      tick(1);
      t++;
    end
    chk("t6_score_arrived", (t < 4 * DB + 8) ? 8'h01 : 8'h00, 8'h01);
    tick(DB + 4);
    chk("t6_score_once", score, 8'h01);
    chk("t6_miss", miss, 8'h00);
    btn = 8'h00; tick(DB + 4);

    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
